// File: rtl/range_pkg.sv
// Shared types and constants for the range reducer.
package range_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StReduce = 2'd1,
    StFix    = 2'd2,
    StDone   = 2'd3
  } state_e;

  localparam logic WRAP  = 1'b0;
  localparam logic CLAMP = 1'b1;

  // Ceiling log2; clog2(0) and clog2(1) both return 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned result;
    v      = (value > 0) ? value - 1 : 0;
    result = 0;
    while (v != 0) begin
      v      = v >> 1;
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/mod_step.sv
// One restoring-division step: shift in a bit, subtract the modulus if it fits.
module mod_step
  import range_pkg::*;
#(
  parameter int MOD   = 100,
  parameter int REM_W = clog2(MOD) + 1
) (
  input  logic [REM_W-1:0] rem_in,
  input  logic             bit_in,
  output logic [REM_W-1:0] rem_out
);

  localparam logic [REM_W:0] MOD_EXT = (REM_W + 1)'(MOD);

  logic [REM_W:0] shifted;
  logic [REM_W:0] reduced;

  // rem_in < MOD, so the shifted value stays below 2*MOD and fits in REM_W bits after reduction
  always_comb begin
    shifted = {rem_in, bit_in};
    reduced = (shifted >= MOD_EXT) ? (shifted - MOD_EXT) : shifted;
    rem_out = reduced[REM_W-1:0];
  end

endmodule

// File: rtl/range_reducer.sv
// Reduces a signed value into 0..MOD-1, either by floor modulo (bit-serial) or by clamping.
module range_reducer
  import range_pkg::*;
#(
  parameter int IN_W  = 10,
  parameter int OUT_W = 7,
  parameter int MOD   = 100
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_val,
  input  logic                    in_mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W-1:0]        out_val,
  output logic                    out_oor,
  output logic                    busy
);

  localparam int REM_W = clog2(MOD) + 1;
  localparam int CNT_W = (clog2(IN_W + 1) > 0) ? clog2(IN_W + 1) : 1;
  localparam logic [REM_W-1:0] MOD_REM  = REM_W'(MOD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_W - 1);

  if (MOD < 2 || MOD > (2 ** OUT_W)) begin : gen_bad_mod
    $fatal(1, "range_reducer: MOD must satisfy 2 <= MOD <= 2**OUT_W");
  end

  state_e                 state_q, state_d;
  logic [IN_W-1:0]        mag_q, mag_d;
  logic [REM_W-1:0]       rem_q, rem_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic signed [IN_W-1:0] val_q, val_d;
  logic                   mode_q, mode_d;
  logic                   out_valid_q, out_valid_d;
  logic [OUT_W-1:0]       out_val_q, out_val_d;
  logic                   out_oor_q, out_oor_d;

  logic                   accept;
  logic [REM_W-1:0]       rem_step;
  logic signed [31:0]     val_ext;
  logic                   is_neg;
  logic                   is_high;
  logic [REM_W-1:0]       neg_rem;
  logic [OUT_W-1:0]       wrap_val;
  logic [OUT_W-1:0]       clamp_val;

  assign in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
  assign accept    = in_valid && in_ready;
  assign busy      = (state_q != StIdle);
  assign out_valid = out_valid_q;
  assign out_val   = out_val_q;
  assign out_oor   = out_oor_q;

  mod_step #(
    .MOD   (MOD),
    .REM_W (REM_W)
  ) u_mod_step (
    .rem_in  (rem_q),
    .bit_in  (mag_q[IN_W-1]),
    .rem_out (rem_step)
  );

  // Result formation from the captured input and the finished remainder
  always_comb begin
    val_ext   = 32'(val_q);
    is_neg    = val_q[IN_W-1];
    is_high   = (val_ext > (MOD - 1));
    neg_rem   = MOD_REM - rem_q;
    if (!is_neg) begin
      wrap_val = OUT_W'(rem_q);
    end else if (rem_q == '0) begin
      wrap_val = '0;
    end else begin
      wrap_val = OUT_W'(neg_rem);
    end
    if (is_neg) begin
      clamp_val = '0;
    end else if (is_high) begin
      clamp_val = OUT_W'(MOD - 1);
    end else begin
      clamp_val = val_ext[OUT_W-1:0];
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_d     = state_q;
    mag_d       = mag_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    val_d       = val_q;
    mode_d      = mode_q;
    out_valid_d = out_valid_q;
    out_val_d   = out_val_q;
    out_oor_d   = out_oor_q;

    unique case (state_q)
      StReduce: begin
        rem_d = rem_step;
        mag_d = {mag_q[IN_W-2:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = StFix;
        end
      end
      StFix: begin
        out_val_d   = (mode_q == CLAMP) ? clamp_val : wrap_val;
        out_oor_d   = is_neg || is_high;
        out_valid_d = 1'b1;
        state_d     = StDone;
      end
      StDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: ;
    endcase

    // Accept covers both IDLE and the back-to-back case in DONE
    if (accept) begin
      val_d       = in_val;
      mode_d      = in_mode;
      mag_d       = in_val[IN_W-1] ? ((~in_val) + IN_W'(1)) : in_val;
      rem_d       = '0;
      cnt_d       = '0;
      out_valid_d = 1'b0;
      state_d     = (in_mode == CLAMP) ? StFix : StReduce;
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      mag_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      val_q       <= '0;
      mode_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_val_q   <= '0;
      out_oor_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mag_q       <= mag_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      val_q       <= val_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      out_val_q   <= out_val_d;
      out_oor_q   <= out_oor_d;
    end
  end

endmodule

// File: tb/tb_range_reducer.sv
// Self-checking bench for range_reducer: vector table, scoreboard, backpressure and reset cases.
module tb_range_reducer;

  localparam int IN_W  = 10;
  localparam int OUT_W = 7;
  localparam int MOD   = 100;
  localparam logic M_WRAP  = 1'b0;
  localparam logic M_CLAMP = 1'b1;
  localparam int NVEC = 15;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   in_valid;
  logic                   in_ready;
  logic signed [IN_W-1:0] in_val;
  logic                   in_mode;
  logic                   out_valid;
  logic                   out_ready;
  logic [OUT_W-1:0]       out_val;
  logic                   out_oor;
  logic                   busy;

  range_reducer #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .MOD   (MOD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_val    (in_val),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_val   (out_val),
    .out_oor   (out_oor),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic mode;
    int   val;
    int   exp_val;
    int   exp_oor;
    int   exp_lat;
  } vec_t;

  typedef struct {
    int v;
    int oor;
  } res_t;

  res_t sb_q[$];
  res_t mon_e;
  vec_t vecs[NVEC];
  int   checks = 0;
  int   errors = 0;
  int   n_out  = 0;
  int   n_exp  = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on every completed output handshake
  always begin
    @(negedge clk);
    #1;
    if (rst_n && out_valid && out_ready) begin
      n_out++;
      if (sb_q.size() == 0) begin
        check("output with empty scoreboard", sb_q.size(), 1);
      end else begin
        mon_e = sb_q.pop_front();
        check("out_val", int'(out_val), mon_e.v);
        check("out_oor", int'(out_oor), mon_e.oor);
      end
    end
  end

  // Present one input, record its expected result, measure edges until out_valid
  // (the accept edge counts as edge 1).
  task automatic do_vec(input logic mode, input int val, input int ev, input int eo,
                        input int elat);
    int   g;
    int   lat;
    res_t r;
    g = 0;
    while (!in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    in_valid = 1'b1;
    in_mode  = mode;
    in_val   = IN_W'(val);
    r.v      = ev;
    r.oor    = eo;
    sb_q.push_back(r);
    n_exp++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_val   = IN_W'($urandom);
    in_mode  = 1'($urandom);
    lat = 1;
    g   = 0;
    @(negedge clk);
    check("busy after accept", int'(busy), 1);
    while (!out_valid && g < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      g++;
    end
    check("latency", out_valid ? lat : -1, elat);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int lat;
    res_t r;

    vecs[0]  = '{M_WRAP,   250, 50, 1, 12};
    vecs[1]  = '{M_WRAP,    -1, 99, 1, 12};
    vecs[2]  = '{M_WRAP,  -100,  0, 1, 12};
    vecs[3]  = '{M_WRAP,  -512, 88, 1, 12};
    vecs[4]  = '{M_WRAP,   511, 11, 1, 12};
    vecs[5]  = '{M_WRAP,    42, 42, 0, 12};
    vecs[6]  = '{M_WRAP,     0,  0, 0, 12};
    vecs[7]  = '{M_WRAP,    99, 99, 0, 12};
    vecs[8]  = '{M_WRAP,   100,  0, 1, 12};
    vecs[9]  = '{M_CLAMP,   -7,  0, 1, 2};
    vecs[10] = '{M_CLAMP,  345, 99, 1, 2};
    vecs[11] = '{M_CLAMP,   99, 99, 0, 2};
    vecs[12] = '{M_CLAMP,  100, 99, 1, 2};
    vecs[13] = '{M_CLAMP,    0,  0, 0, 2};
    vecs[14] = '{M_WRAP,  -101, 99, 1, 12};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_mode   = 1'b0;
    in_val    = '0;
    out_ready = 1'b1;

    #12;
    check("reset out_valid", int'(out_valid), 0);
    check("reset out_val", int'(out_val), 0);
    check("reset out_oor", int'(out_oor), 0);
    check("reset busy", int'(busy), 0);
    check("reset in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready after reset", int'(in_ready), 1);

    // Table vectors; with out_ready high consecutive vectors are accepted back-to-back
    for (int i = 0; i < NVEC; i++) begin
      do_vec(vecs[i].mode, vecs[i].val, vecs[i].exp_val, vecs[i].exp_oor, vecs[i].exp_lat);
    end

    // Backpressure: hold the result for 5 cycles with a second input waiting
    @(negedge clk);
    out_ready = 1'b0;
    do_vec(M_WRAP, 250, 50, 1, 12);
    in_valid = 1'b1;
    in_mode  = M_CLAMP;
    in_val   = IN_W'(345);
    for (int i = 0; i < 5; i++) begin
      check("held out_valid", int'(out_valid), 1);
      check("held out_val", int'(out_val), 50);
      check("in_ready under backpressure", int'(in_ready), 0);
      @(posedge clk);
      @(negedge clk);
    end
    out_ready = 1'b1;
    r.v   = 99;
    r.oor = 1;
    sb_q.push_back(r);
    n_exp++;
    #0;
    check("in_ready on release", int'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    g   = 0;
    @(negedge clk);
    while (!out_valid && g < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      g++;
    end
    check("back-to-back clamp latency", out_valid ? lat : -1, 2);

    // Reset in the 4th REDUCE cycle aborts the operation
    @(negedge clk);
    @(negedge clk);
    g = 0;
    while (!in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    in_valid = 1'b1;
    in_mode  = M_WRAP;
    in_val   = IN_W'(123);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async reset busy", int'(busy), 0);
    check("async reset out_valid", int'(out_valid), 0);
    check("async reset out_val", int'(out_val), 0);
    check("async reset in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no result after abort", int'(out_valid), 0);
    end
    do_vec(M_WRAP, 73, 73, 0, 12);

    repeat (3) @(negedge clk);
    check("scoreboard drained", sb_q.size(), 0);
    check("output count", n_out, n_exp);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/range_reducer.md
RANGE_REDUCER -- requirements
Module: range_reducer

Interface
REQ-001 Parameter IN_W, default 10, width of signed input value.
REQ-002 Parameter OUT_W, default 7, width of unsigned result.
REQ-003 Parameter MOD, default 100, modulus; legal range 2 <= MOD <= 2^OUT_W.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  in_val/in_mode are presented.
REQ-007 in_ready  output  1  block can accept input this cycle.
REQ-008 in_val  input  IN_W  signed two's-complement value to reduce.
REQ-009 in_mode  input  1  0 = WRAP (floor modulo), 1 = CLAMP (saturate to 0..MOD-1).
REQ-010 out_valid  output  1  out_val/out_oor are valid.
REQ-011 out_ready  input  1  consumer accepts result this cycle.
REQ-012 out_val  output  OUT_W  result, always in 0..MOD-1.
REQ-013 out_oor  output  1  input was outside 0..MOD-1.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 States: IDLE, REDUCE, FIX, DONE.
REQ-016 Accept = in_valid && in_ready at a rising edge; in_val, in_mode and sign are captured at that edge only.
REQ-017 in_ready is high in IDLE, and in DONE when out_ready is high (back-to-back accept); low otherwise.
REQ-018 On accept in WRAP: load |in_val| as an IN_W-bit unsigned magnitude (covers -2^(IN_W-1)), clear remainder, go to REDUCE.
REQ-019 REDUCE runs exactly IN_W cycles, MSB first, one magnitude bit per cycle: r = (r<<1)|bit; if r >= MOD then r = r - MOD.
REQ-020 Remainder register width is clog2(MOD)+1 bits; no intermediate value may overflow it.
REQ-021 After the last REDUCE cycle go to FIX; FIX: positive input gives out_val = r; negative input gives out_val = (r == 0) ? 0 : MOD - r (true floor modulo, e.g. -1 -> MOD-1).
REQ-022 On accept in CLAMP: skip REDUCE, go directly to FIX; out_val = 0 if in_val < 0, MOD-1 if in_val > MOD-1, else in_val[OUT_W-1:0].
REQ-023 FIX computes out_oor = (in_val < 0) || (in_val > MOD-1) in both modes.
REQ-024 FIX -> DONE with out_valid high: WRAP latency IN_W+2 edges after accept edge; CLAMP latency 2 edges.
REQ-025 In DONE, out_val/out_oor/out_valid are held stable until out_ready is high.
REQ-026 DONE with out_ready: if a new accept occurs in the same cycle, go to REDUCE/FIX per new mode; else go to IDLE with out_valid low.
REQ-027 in_valid outside accept cycles is ignored; in_val changes during REDUCE have no effect.

Reset
REQ-028 rst_n low forces immediately, independent of clk: state IDLE, out_valid 0, out_val 0, out_oor 0, busy 0, remainder and capture registers 0.
REQ-029 Reset asserted mid-operation aborts the operation; no result is delivered for it.
REQ-030 in_ready is 1 during and immediately after reset (IDLE).

Structure
REQ-031 Package range_pkg holds the state enum, the mode constants WRAP/CLAMP, and a clog2 helper function.
REQ-032 One combinational sub-module, mod_step, performs a single shift-compare-subtract step (REQ-019); range_reducer instantiates it once.
REQ-033 Elaboration fails if MOD < 2 or MOD > 2^OUT_W.

Verification (defaults IN_W=10, OUT_W=7, MOD=100)
REQ-034 WRAP in_val=250 -> out_val=50, out_oor=1, out_valid exactly 12 edges after accept.
REQ-035 WRAP in_val=-1 -> 99; -100 -> 0; -512 -> 88; 511 -> 11; 42 -> 42 with out_oor=0.
REQ-036 CLAMP in_val=-7 -> 0, oor=1; 345 -> 99, oor=1; 99 -> 99, oor=0; out_valid 2 edges after accept.
REQ-037 Backpressure: out_ready low 5 cycles after result -> out_val held, in_ready low; then out_ready high with in_valid high -> second input accepted in the same cycle, results in order.
REQ-038 rst_n pulsed low in 4th REDUCE cycle -> out_valid stays 0, busy 0 asynchronously, next input 73 -> 73 correct.
